// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO request arbiter: FSM states, MDIO field
// widths and the default response timeout.
package mdio_pkg;

  localparam int MDIO_ADDR_W = 5;
  localparam int MDIO_DATA_W = 16;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: searches from last_grant+1 (mod NUM_REQ)
// and returns the first requesting index as one-hot and binary.
module rr_arbiter
  import mdio_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  int  j;
  logic found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_grant_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j[IDX_W-1:0]]) begin
        found                      = 1'b1;
        grant_o[j[IDX_W-1:0]]      = 1'b1;
        grant_idx_o                = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mdio_arb.sv
// Shares one MDIO driver between NUM_REQ clients. A client holds req_valid
// until it sees the one-cycle req_ready pulse; rsp_done later pulses once.
module mdio_arb
  import mdio_pkg::*;
#(
  parameter int          NUM_REQ = 3,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rh_wl,
  input  logic [MDIO_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [MDIO_DATA_W*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_done,
  output logic [MDIO_DATA_W-1:0]         rsp_rd_data,
  output logic                           rsp_rd_ack,
  output logic                           rsp_timeout,
  output logic                           op_exec,
  output logic                           op_rh_wl,
  output logic [MDIO_ADDR_W-1:0]         op_addr,
  output logic [MDIO_DATA_W-1:0]         op_wr_data,
  input  logic                           op_done,
  input  logic [MDIO_DATA_W-1:0]         op_rd_data,
  input  logic                           op_rd_ack,
  output state_e                         dbg_state
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         last_grant_q, last_grant_d;
  logic [IDX_W-1:0]         gidx_q, gidx_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [NUM_REQ-1:0]       req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]       rsp_done_q, rsp_done_d;
  logic [MDIO_DATA_W-1:0]   rsp_rd_data_q, rsp_rd_data_d;
  logic                     rsp_rd_ack_q, rsp_rd_ack_d;
  logic                     rsp_timeout_q, rsp_timeout_d;
  logic                     op_exec_q, op_exec_d;
  logic                     op_rh_wl_q, op_rh_wl_d;
  logic [MDIO_ADDR_W-1:0]   op_addr_q, op_addr_d;
  logic [MDIO_DATA_W-1:0]   op_wr_data_q, op_wr_data_d;

  logic [NUM_REQ-1:0]       arb_grant;
  logic [IDX_W-1:0]         arb_idx;
  logic [MDIO_ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [MDIO_DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*MDIO_ADDR_W +: MDIO_ADDR_W];
    assign wdata_arr[i] = req_wr_data[i*MDIO_DATA_W +: MDIO_DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gidx_d        = gidx_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    rsp_done_d    = '0;
    rsp_rd_data_d = rsp_rd_data_q;
    rsp_rd_ack_d  = rsp_rd_ack_q;
    rsp_timeout_d = rsp_timeout_q;
    op_exec_d     = 1'b0;
    op_rh_wl_d    = op_rh_wl_q;
    op_addr_d     = op_addr_q;
    op_wr_data_d  = op_wr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          req_ready_d  = arb_grant;
          gnt_d        = arb_grant;
          gidx_d       = arb_idx;
          op_rh_wl_d   = req_rh_wl[arb_idx];
          op_addr_d    = addr_arr[arb_idx];
          op_wr_data_d = wdata_arr[arb_idx];
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        op_exec_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving in the expiry cycle still returns the PHY's answer.
        if (op_done) begin
          rsp_done_d    = gnt_q;
          rsp_rd_data_d = op_rd_data;
          rsp_rd_ack_d  = op_rd_ack;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          rsp_done_d    = gnt_q;
          rsp_rd_data_d = '0;
          rsp_rd_ack_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        last_grant_d  = gidx_q;
        rsp_rd_data_d = '0;
        rsp_rd_ack_d  = 1'b0;
        rsp_timeout_d = 1'b0;
        op_rh_wl_d    = 1'b0;
        op_addr_d     = '0;
        op_wr_data_d  = '0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      gidx_q        <= '0;
      gnt_q         <= '0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      rsp_done_q    <= '0;
      rsp_rd_data_q <= '0;
      rsp_rd_ack_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      op_exec_q     <= 1'b0;
      op_rh_wl_q    <= 1'b0;
      op_addr_q     <= '0;
      op_wr_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gidx_q        <= gidx_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_done_q    <= rsp_done_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      rsp_rd_ack_q  <= rsp_rd_ack_d;
      rsp_timeout_q <= rsp_timeout_d;
      op_exec_q     <= op_exec_d;
      op_rh_wl_q    <= op_rh_wl_d;
      op_addr_q     <= op_addr_d;
      op_wr_data_q  <= op_wr_data_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_done    = rsp_done_q;
  assign rsp_rd_data = rsp_rd_data_q;
  assign rsp_rd_ack  = rsp_rd_ack_q;
  assign rsp_timeout = rsp_timeout_q;
  assign op_exec     = op_exec_q;
  assign op_rh_wl    = op_rh_wl_q;
  assign op_addr     = op_addr_q;
  assign op_wr_data  = op_wr_data_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mdio_arb.sv
// Bench for mdio_arb: directed scenarios plus randomized traffic, checked
// against a round-robin/timeout reference model kept in the bench.
module tb_mdio_arb;
  import mdio_pkg::*;

  localparam int NREQ = 3;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req_valid = '0;
  logic [2:0]    req_rh_wl = '0;
  logic [14:0]   req_addr = '0;
  logic [47:0]   req_wr_data = '0;
  logic [2:0]    req_ready, rsp_done;
  logic [15:0]   rsp_rd_data;
  logic          rsp_rd_ack, rsp_timeout;
  logic          op_exec, op_rh_wl;
  logic [4:0]    op_addr;
  logic [15:0]   op_wr_data;
  logic          op_done = 1'b0;
  logic [15:0]   op_rd_data = '0;
  logic          op_rd_ack = 1'b0;
  state_e        dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  int last_g = NREQ - 1;
  logic [15:0] exp_q[$];

  mdio_arb #(.NUM_REQ(NREQ), .TIMEOUT(16'd16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rh_wl(req_rh_wl), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_ready(req_ready), .rsp_done(rsp_done),
    .rsp_rd_data(rsp_rd_data), .rsp_rd_ack(rsp_rd_ack), .rsp_timeout(rsp_timeout),
    .op_exec(op_exec), .op_rh_wl(op_rh_wl), .op_addr(op_addr), .op_wr_data(op_wr_data),
    .op_done(op_done), .op_rd_data(op_rd_data), .op_rd_ack(op_rd_ack),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: first valid requester after the last served one
  function automatic int ref_grant(input logic [2:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last_g + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int r, input logic rw, input logic [4:0] a, input logic [15:0] d);
    req_valid[r]             = 1'b1;
    req_rh_wl[r]             = rw;
    req_addr[r*5 +: 5]       = a;
    req_wr_data[r*16 +: 16]  = d;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, req_ready, 3'b000);
    check({tag, "_rsp_done"}, rsp_done, 3'b000);
    check({tag, "_op_exec"}, op_exec, 1'b0);
    check({tag, "_op_addr"}, op_addr, 5'h00);
    check({tag, "_op_wr_data"}, op_wr_data, 16'h0000);
    check({tag, "_rsp_rd_data"}, rsp_rd_data, 16'h0000);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // One full transaction. d = cycles after op_exec before op_done; d >= TO
  // means the driver never answers.
  task automatic run_op(input int d, input logic [15:0] rdat, input logic rack);
    int g;
    int n_wait;
    logic to, got, erw;
    logic [4:0] ea;
    logic [15:0] ew, exp_data;
    g = ref_grant(req_valid);
    if (g < 0) return;
    erw = req_rh_wl[g];
    ea  = req_addr[g*5 +: 5];
    ew  = req_wr_data[g*16 +: 16];
    to  = (d >= TO);
    exp_q.push_back(to ? 16'h0000 : rdat);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      if (req_ready != 3'b000) got = 1'b1;
    end
    check("req_ready_seen", got, 1'b1);
    if (!got) return;
    check("req_ready_onehot", req_ready, 3'b001 << g);
    req_valid[g] = 1'b0;
    tick();
    check("op_exec", op_exec, 1'b1);
    check("op_rh_wl", op_rh_wl, erw);
    check("op_addr", op_addr, ea);
    check("op_wr_data", op_wr_data, ew);
    n_wait = to ? TO : d + 1;
    for (int c = 0; c < n_wait; c++) begin
      if (!to && c == d) begin
        op_done = 1'b1; op_rd_data = rdat; op_rd_ack = rack;
      end
      if (c == n_wait - 1) check("rsp_early", rsp_done, 3'b000);
      tick();
      op_done = 1'b0; op_rd_data = $urandom_range(0, 65535); op_rd_ack = 1'($urandom_range(0, 1));
    end
    exp_data = exp_q.pop_front();
    check("rsp_done", rsp_done, 3'b001 << g);
    check("rsp_timeout", rsp_timeout, to);
    check("rsp_rd_ack", rsp_rd_ack, to ? 1'b1 : rack);
    check("rsp_rd_data", rsp_rd_data, exp_data);
    check("op_addr_hold", op_addr, ea);
    check("op_exec_low", op_exec, 1'b0);
    tick();
    check("rsp_done_clear", rsp_done, 3'b000);
    check("back_idle", dbg_state, ST_IDLE);
    last_g = g;
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    check_quiet("reset_hold");
    rst = 1'b0;
    tick();
    check_quiet("reset_release");

    // op_done while idle is ignored
    op_done = 1'b1; tick(); op_done = 1'b0; tick();
    check_quiet("idle_done");

    // single write from requester 0
    set_req(0, 1'b0, 5'h00, 16'h9140);
    run_op(3, 16'h1234, 1'b0);

    // read from requester 2
    set_req(2, 1'b1, 5'h11, 16'h0000);
    run_op(5, 16'h7C00, 1'b0);

    // timeout and collision
    set_req(1, 1'b1, 5'h02, 16'h0000);
    run_op(TO + 5, 16'hFFFF, 1'b0);
    set_req(0, 1'b1, 5'h03, 16'h0000);
    run_op(TO - 1, 16'hBEEF, 1'b0);

    // fairness: everyone held valid, served requester re-requests afterwards
    set_req(0, 1'b0, 5'h04, 16'hA000);
    set_req(1, 1'b0, 5'h05, 16'hA001);
    set_req(2, 1'b0, 5'h06, 16'hA002);
    for (int i = 0; i < 6; i++) begin
      run_op(2, 16'h5A5A, 1'b1);
      set_req(last_g, 1'b1, 5'(i), 16'(i));
    end
    while (req_valid != 3'b000) run_op(1, 16'h0F0F, 1'b0);

    // reset in WAIT, then late op_done
    set_req(1, 1'b1, 5'h1F, 16'hCAFE);
    begin
      logic got;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        tick();
        if (req_ready != 3'b000) got = 1'b1;
      end
      check("rw_req_ready_seen", got, 1'b1);
    end
    req_valid[1] = 1'b0;
    repeat (3) tick();
    check("rw_in_wait", dbg_state, ST_WAIT);
    rst = 1'b1;
    #1;
    check_quiet("rw_async");
    tick();
    rst = 1'b0;
    last_g = NREQ - 1;
    op_done = 1'b1; op_rd_data = 16'h1111;
    tick();
    op_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rw_no_rsp", rsp_done, 3'b000);
      tick();
    end
    check_quiet("rw_after");
    set_req(2, 1'b0, 5'h07, 16'h0007);
    set_req(1, 1'b0, 5'h08, 16'h0008);
    set_req(0, 1'b0, 5'h09, 16'h0009);
    run_op(0, 16'h2222, 1'b0);
    while (req_valid != 3'b000) run_op(4, 16'h3333, 1'b1);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      logic [2:0] v;
      int d;
      v = 3'($urandom_range(1, 7));
      for (int r = 0; r < NREQ; r++)
        if (v[r] && !req_valid[r])
          set_req(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  16'($urandom_range(0, 65535)));
      case ($urandom_range(0, 4))
        0:       d = TO - 1;
        1:       d = TO + 2;
        default: d = $urandom_range(0, TO + 2);
      endcase
      run_op(d, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end
    while (req_valid != 3'b000) run_op($urandom_range(0, 6), 16'($urandom_range(0, 65535)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
